// File: rtl/lsu_bus_if.sv
// rtl/lsu_bus_if.sv - load/store unit bridging the core datapath to a req/ack data bus
// Formats store lanes on issue and load results on ack; stalls the core while a transfer is in flight.
module lsu_bus_if #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        misalign,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] baddr_q, baddr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] bwdata_q, bwdata_d;
  logic [31:0] rdata_q, rdata_d;

  logic        access, is_store, size_half, size_word, f3_legal, go;
  logic [3:0]  st_be;
  logic [31:0] st_wdata, lane, ld_data;

  // A store wins when both controls are set, so sign/unsigned-only encodings are illegal for it.
  assign access    = memread | memwrite;
  assign is_store  = memwrite;
  assign size_half = (funct3[1:0] == 2'b01);
  assign size_word = (funct3[1:0] == 2'b10);
  assign f3_legal  = (funct3[1:0] != 2'b11) && (!funct3[2] || (!is_store && !size_word));

  assign misalign = (state_q == IDLE) && access &&
                    (!f3_legal || (size_half && addr[0]) || (size_word && (addr[1:0] != 2'b00)));
  assign go       = (state_q == IDLE) && access && !misalign;
  assign stall    = go || (state_q == BUSY);
  assign rdata    = (state_q == DONE) ? rdata_q : 32'h0;

  assign bus_err   = err_q;
  assign bus_req   = req_q;
  assign bus_we    = we_q;
  assign bus_addr  = baddr_q;
  assign bus_be    = be_q;
  assign bus_wdata = bwdata_q;

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = wdata;
    case (funct3[1:0])
      2'b00: begin
        st_be    = 4'b0001 << addr[1:0];
        st_wdata = {4{wdata[7:0]}};
      end
      2'b01: begin
        st_be    = 4'b0011 << addr[1:0];
        st_wdata = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign lane = bus_rdata >> {addr[1:0], 3'b000};

  always_comb begin
    ld_data = bus_rdata;
    case (funct3)
      3'b000:  ld_data = {{24{lane[7]}}, lane[7:0]};
      3'b100:  ld_data = {24'h0, lane[7:0]};
      3'b001:  ld_data = {{16{lane[15]}}, lane[15:0]};
      3'b101:  ld_data = {16'h0, lane[15:0]};
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    req_d    = req_q;
    we_d     = we_q;
    baddr_d  = baddr_q;
    be_d     = be_q;
    bwdata_d = bwdata_q;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        if (go) begin
          state_d  = BUSY;
          req_d    = 1'b1;
          we_d     = is_store;
          baddr_d  = {addr[31:2], 2'b00};
          be_d     = is_store ? st_be : 4'b1111;
          bwdata_d = is_store ? st_wdata : 32'h0;
          rdata_d  = 32'h0;
          cnt_d    = 8'h0;
        end
      end
      BUSY: begin
        if (bus_ack) begin
          state_d = DONE;
          req_d   = 1'b0;
          rdata_d = we_q ? 32'h0 : ld_data;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          req_d   = 1'b0;
          err_d   = 1'b1;
          rdata_d = 32'h0;
        end else begin
          cnt_d = cnt_q + 8'h1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 8'h0;
      err_q    <= 1'b0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      baddr_q  <= 32'h0;
      be_q     <= 4'h0;
      bwdata_q <= 32'h0;
      rdata_q  <= 32'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      req_q    <= req_d;
      we_q     <= we_d;
      baddr_q  <= baddr_d;
      be_q     <= be_d;
      bwdata_q <= bwdata_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule

// File: tb/tb_lsu_bus_if.sv
// tb/tb_lsu_bus_if.sv - randomized and directed bench for lsu_bus_if
// Expected values come from an arithmetic model of the access rules.
module tb_lsu_bus_if;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memread = 1'b0, memwrite = 1'b0;
  logic [2:0]  funct3 = 3'b0;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic [31:0] rdata;
  logic        stall, misalign, bus_err, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'h0;

  int total = 0;
  int bad = 0;
  logic exp_err = 1'b0;

  lsu_bus_if #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite),
    .funct3(funct3), .addr(addr), .wdata(wdata), .rdata(rdata),
    .stall(stall), .misalign(misalign), .bus_err(bus_err), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  // One access end to end; waits >= TMO means the bus never acks.
  task automatic run_access(input logic mr, input logic mw, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] rd, input int waits);
    logic        st, legal, mis, tmo;
    int          nbytes, off, busy_n, stall_n;
    logic [31:0] exp_be, exp_wd, exp_rd, v;
    st     = mw;
    legal  = (f3 <= 3'd2) || (!mw && (f3 == 3'd4 || f3 == 3'd5));
    nbytes = 1 << f3[1:0];
    off    = a % 4;
    mis    = (mr || mw) && (!legal || ((a % nbytes) != 0));
    tmo    = (waits >= TMO);
    exp_be = st ? (((1 << nbytes) - 1) << off) : 32'hF;
    if (nbytes == 1) exp_wd = wd[7:0] * 32'h01010101;
    else if (nbytes == 2) exp_wd = wd[15:0] * 32'h00010001;
    else exp_wd = wd;
    v = rd >> (8 * off);
    if (nbytes == 1) begin
      v = v & 32'hFF;
      if (!f3[2] && v >= 32'd128) v = v - 32'd256;
    end else if (nbytes == 2) begin
      v = v & 32'hFFFF;
      if (!f3[2] && v >= 32'd32768) v = v - 32'd65536;
    end
    exp_rd = (st || tmo) ? 32'h0 : v;

    memread = mr; memwrite = mw; funct3 = f3; addr = a; wdata = wd;
    bus_rdata = rd; bus_ack = 1'b0;
    #1;
    total++; if (misalign !== mis) begin bad++; $display("FAIL misalign: got %b want %b (f3=%0d a=%h)", misalign, mis, f3, a); end
    if (mis) begin
      total++; if (stall !== 1'b0 || rdata !== 32'h0) begin bad++; $display("FAIL mis_idle: stall=%b rdata=%h want 0/0", stall, rdata); end
      @(posedge clk); #1;
      total++; if (bus_req !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL mis_noreq: bus_req=%b stall=%b want 0/0", bus_req, stall); end
    end else begin
      total++; if (stall !== 1'b1 || rdata !== 32'h0) begin bad++; $display("FAIL issue: stall=%b rdata=%h want 1/0", stall, rdata); end
      stall_n = 1;
      @(posedge clk); #1;
      total++; if (bus_req !== 1'b1 || bus_we !== st) begin bad++; $display("FAIL req: bus_req=%b bus_we=%b want 1/%b", bus_req, bus_we, st); end
      total++; if (bus_addr !== (a & ~32'h3)) begin bad++; $display("FAIL bus_addr: got %h want %h", bus_addr, a & ~32'h3); end
      total++; if (bus_be !== exp_be[3:0]) begin bad++; $display("FAIL bus_be: got %b want %b", bus_be, exp_be[3:0]); end
      if (st) begin
        total++; if (bus_wdata !== exp_wd) begin bad++; $display("FAIL bus_wdata: got %h want %h", bus_wdata, exp_wd); end
      end
      busy_n = tmo ? TMO : waits + 1;
      for (int n = 0; n < busy_n; n++) begin
        if (stall === 1'b1) stall_n++;
        total++; if (bus_req !== 1'b1 || rdata !== 32'h0) begin bad++; $display("FAIL busy: bus_req=%b rdata=%h want 1/0", bus_req, rdata); end
        bus_ack = (!tmo && n == waits);
        @(posedge clk); #1;
        bus_ack = 1'b0;
      end
      exp_err = exp_err | tmo;
      total++; if (stall !== 1'b0 || bus_req !== 1'b0) begin bad++; $display("FAIL done: stall=%b bus_req=%b want 0/0", stall, bus_req); end
      total++; if (rdata !== exp_rd) begin bad++; $display("FAIL rdata: got %h want %h (f3=%0d a=%h)", rdata, exp_rd, f3, a); end
      total++; if (bus_err !== exp_err) begin bad++; $display("FAIL bus_err: got %b want %b", bus_err, exp_err); end
      total++; if (stall_n != busy_n + 1) begin bad++; $display("FAIL stall_cycles: got %0d want %0d", stall_n, busy_n + 1); end
      @(posedge clk); #1;
    end
    memread = 1'b0; memwrite = 1'b0;
    #1;
    total++; if (stall !== 1'b0 || rdata !== 32'h0 || bus_req !== 1'b0) begin bad++; $display("FAIL idle_after: stall=%b rdata=%h bus_req=%b want 0", stall, rdata, bus_req); end
  endtask

  task automatic test_reset;
    #2;
    total++; if (bus_req !== 1'b0 || bus_we !== 1'b0 || bus_addr !== 32'h0 || bus_be !== 4'h0 || bus_wdata !== 32'h0)
      begin bad++; $display("FAIL reset_bus: req=%b we=%b addr=%h be=%b wd=%h want all 0", bus_req, bus_we, bus_addr, bus_be, bus_wdata); end
    total++; if (rdata !== 32'h0 || bus_err !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL reset_out: rdata=%h err=%b stall=%b want 0", rdata, bus_err, stall); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_lw;
    run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0);
  endtask

  task automatic test_lb_waits;
    run_access(1'b1, 1'b0, 3'b000, 32'h203, 32'h0, 32'h80FFFFFF, 3);
    run_access(1'b1, 1'b0, 3'b100, 32'h203, 32'h0, 32'h80FFFFFF, 3);
    run_access(1'b1, 1'b0, 3'b001, 32'h602, 32'h0, 32'h9abc1234, 1);
    run_access(1'b1, 1'b0, 3'b101, 32'h602, 32'h0, 32'h9abc1234, 2);
  endtask

  task automatic test_store;
    run_access(1'b0, 1'b1, 3'b000, 32'h301, 32'h123456AB, 32'hFFFFFFFF, 0);
    run_access(1'b0, 1'b1, 3'b001, 32'h302, 32'h1234CDEF, 32'h0, 1);
    run_access(1'b1, 1'b1, 3'b010, 32'h304, 32'hCAFEF00D, 32'h55555555, 0);
  endtask

  task automatic test_misalign;
    run_access(1'b1, 1'b0, 3'b001, 32'h401, 32'h0, 32'h0, 0);
    run_access(1'b1, 1'b0, 3'b011, 32'h400, 32'h0, 32'h0, 0);
    run_access(1'b1, 1'b0, 3'b010, 32'h402, 32'h0, 32'h0, 0);
    run_access(1'b0, 1'b1, 3'b100, 32'h400, 32'h0, 32'h0, 0);
  endtask

  task automatic test_timeout;
    run_access(1'b1, 1'b0, 3'b010, 32'h700, 32'h0, 32'h11111111, 100);
    run_access(1'b1, 1'b0, 3'b010, 32'h704, 32'h0, 32'h22222222, 0);
  endtask

  task automatic test_ack_ignored;
    bus_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus_req !== 1'b0 || stall !== 1'b0 || rdata !== 32'h0) begin bad++; $display("FAIL ack_idle: req=%b stall=%b rdata=%h want 0", bus_req, stall, rdata); end
    bus_ack = 1'b0;
  endtask

  task automatic test_reset_mid;
    memread = 1'b1; funct3 = 3'b010; addr = 32'h500;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus_req !== 1'b1) begin bad++; $display("FAIL mid_busy: bus_req=%b want 1", bus_req); end
    #1 reset = 1'b1; memread = 1'b0;
    #1;
    exp_err = 1'b0;
    total++; if (bus_req !== 1'b0 || stall !== 1'b0 || bus_err !== 1'b0) begin bad++; $display("FAIL mid_reset: req=%b stall=%b err=%b want 0", bus_req, stall, bus_err); end
    @(posedge clk); #1;
    reset = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    total++; if (bus_req !== 1'b0 || rdata !== 32'h0 || stall !== 1'b0) begin bad++; $display("FAIL mid_ack: req=%b rdata=%h stall=%b want 0", bus_req, rdata, stall); end
    run_access(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 32'h0BADF00D, 0);
  endtask

  task automatic test_back_to_back;
    run_access(1'b1, 1'b0, 3'b000, 32'h801, 32'h0, 32'h00007F00, 0);
    run_access(1'b0, 1'b1, 3'b010, 32'h800, 32'hA5A5A5A5, 32'h0, 0);
    run_access(1'b1, 1'b0, 3'b101, 32'h802, 32'h0, 32'h8001FFFF, 0);
  endtask

  task automatic test_random;
    logic        mr, mw;
    logic [2:0]  f3;
    logic [31:0] a;
    int          k;
    for (int i = 0; i < 60; i++) begin
      k  = $urandom_range(0, 2);
      mr = (k != 1);
      mw = (k != 0);
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      if ($urandom_range(0, 1) == 1) a = a & ~32'h3;
      run_access(mr, mw, f3, a, $urandom, $urandom, $urandom_range(0, 5));
    end
  endtask

  initial begin
    test_reset;
    test_lw;
    test_lb_waits;
    test_store;
    test_misalign;
    test_ack_ignored;
    test_timeout;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_bus_if.md
Name: lsu_bus_if

Overview:
- Load/store unit directly downstream of the core datapath.
- Consumes the datapath's ALU address, store data and memory controls.
- Runs a multi-cycle req/ack transaction on the data bus.
- Returns aligned, extended load data to the datapath's read-data input and stalls the core (PC hold) while a transfer is in flight.

Parameters:
- TIMEOUT_CYCLES, 64: max BUSY cycles without bus_ack before abort (range 1..255).

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-high.
- memread  in  1  load request for the current instruction.
- memwrite  in  1  store request for the current instruction.
- funct3  in  3  access size/sign (instr[14:12]).
- addr  in  32  byte address (datapath aluout).
- wdata  in  32  store data (datapath writedata, rs2).
- rdata  out  32  formatted load result to datapath readdata.
- stall  out  1  hold PC/regfile write this cycle.
- misalign  out  1  current access misaligned or illegal funct3; no bus access issued.
- bus_err  out  1  sticky timeout flag.
- bus_req  out  1  bus request.
- bus_we  out  1  1=write.
- bus_addr  out  32  word address {addr[31:2],2'b00}.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-replicated store data.
- bus_ack  in  1  transfer complete; bus_rdata valid same cycle.
- bus_rdata  in  32  read word.

Behaviour:
- Reset (async):
  - State=IDLE.
  - bus_req, bus_we, bus_addr, bus_be, bus_wdata, rdata register, timeout counter and bus_err all 0.
  - Reset mid-transaction drops bus_req immediately; no completion is reported.
- access = memread|memwrite.
- If both memread and memwrite are set, the access is a store.
- Legal funct3:
  - 000 LB/SB, 001 LH/SH, 010 LW/SW.
  - 100 LBU, 101 LHU (loads only).
  - All others are illegal.
- misalign (combinational, IDLE only) = access & (illegal funct3 | half with addr[0]=1 | word with addr[1:0]!=0).
  - When misalign=1: no bus request, stall=0, rdata=0, state stays IDLE.
- IDLE:
  - On access & !misalign: stall=1 combinationally.
  - Register bus_addr, bus_we, bus_be and bus_wdata; set bus_req=1 and clear the counter.
  - Go to BUSY.
- BUSY:
  - stall=1; all bus outputs held stable.
  - On bus_ack: capture the formatted load result (loads only), drop bus_req, go to DONE.
  - Without bus_ack: counter increments. When counter reaches TIMEOUT_CYCLES-1 with no ack, drop bus_req, set bus_err=1, load rdata register=0, go to DONE.
- DONE:
  - stall=0; rdata = captured value; core retires the instruction at this edge.
  - Next state IDLE unconditionally. A back-to-back access starts on the following cycle.
- bus_ack outside BUSY is ignored.
- Latency:
  - Zero-wait ack gives 3 cycles (IDLE stall, BUSY ack, DONE).
  - Each wait state adds 1 cycle.
- Store byte enables and data:
  - SB: be=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}}.
  - SH: be=4'b0011<<addr[1:0], wdata={2{wdata[15:0]}}.
  - SW: be=4'b1111, wdata unchanged.
- Loads: bus_be=4'b1111. Lane select by addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW is the word unchanged.
- rdata is 0 in IDLE and BUSY, and after stores.
- bus_err clears only on reset.
- The core holds addr, funct3 and controls stable while stall=1. The unit samples them only at the IDLE→BUSY edge and during the DONE formatting.

Test Plan:
- LW addr=0x100, ack in first BUSY cycle, bus_rdata=0xDEADBEEF → bus_addr=0x100, be=1111, stall high 2 cycles, DONE rdata=0xDEADBEEF.
- LB addr=0x203, 3 wait states, bus_rdata=0x80FFFFFF → stall 5 cycles, rdata=0xFFFFFF80; LBU same → 0x00000080.
- SB addr=0x301, wdata=0x123456AB → bus_we=1, bus_addr=0x300, be=0010, bus_wdata=0xABABABAB, rdata=0.
- LH addr=0x401 → misalign=1, stall=0, bus_req never asserted; funct3=011 load → misalign=1.
- LW with bus_ack held low, TIMEOUT_CYCLES=4 → bus_req drops after 4 BUSY cycles, bus_err=1 sticky, rdata=0 in DONE.
- Reset asserted in BUSY after 2 cycles → bus_req=0 asynchronously, state IDLE, later ack ignored, next LW completes normally.
